// File: rtl/lcd_bus_controller_pkg.sv
// Shared LCD controller definitions: default timings, HD44780 command codes, FSM encodings.
// Also holds the boot-item lookup and timer-load helpers used by both the top and nibble writer.
package lcd_bus_controller_pkg;

  localparam int unsigned TIMER_W = 20;

  localparam int unsigned DEF_T_POWERON = 750000;
  localparam int unsigned DEF_T_INIT1   = 205000;
  localparam int unsigned DEF_T_INIT2   = 5000;
  localparam int unsigned DEF_T_SETUP   = 2;
  localparam int unsigned DEF_T_ENABLE  = 12;
  localparam int unsigned DEF_T_HOLD    = 1;
  localparam int unsigned DEF_T_NIBGAP  = 50;
  localparam int unsigned DEF_T_EXEC    = 2000;
  localparam int unsigned DEF_T_CLEAR   = 82000;

  localparam logic [7:0] LCD_FUNCSET = 8'h28;
  localparam logic [7:0] LCD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_HOME    = 8'h02;

  typedef logic [TIMER_W-1:0] timer_t;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_CFG,
    ST_IDLE,
    ST_NIB,
    ST_GAP,
    ST_EXEC
  } ctrl_state_t;

  typedef enum logic [1:0] {
    NW_IDLE,
    NW_SETUP,
    NW_PULSE,
    NW_HOLD
  } nib_state_t;

  // A phase of N cycles loads N-1 and exits on the cycle the count hits zero.
  function automatic timer_t tload(input int unsigned cycles);
    return (cycles == 0) ? '0 : timer_t'(cycles - 1);
  endfunction

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == LCD_CLEAR) || (b == LCD_HOME));
  endfunction

  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = LCD_FUNCSET;
      2'd1:    b = LCD_ENTRY;
      2'd2:    b = LCD_DISPON;
      default: b = LCD_CLEAR;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_bus_controller_if.sv
// CPU write port plus LCD pin bundle; the CPU side drives wr_*, the controller drives rdy and pins.
// wr_vld is a one-cycle strobe, honoured only while rdy is high.
interface lcd_bus_controller_if;
  logic       wr_vld;
  logic       wr_rs;
  logic [7:0] wr_dat;
  logic       rdy;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_dat;

  modport master (
    output wr_vld, wr_rs, wr_dat,
    input  rdy, lcd_e, lcd_rs, lcd_rw, lcd_dat
  );

  modport slave (
    input  wr_vld, wr_rs, wr_dat,
    output rdy, lcd_e, lcd_rs, lcd_rw, lcd_dat
  );
endinterface

// File: rtl/lcd_nibble_writer.sv
// Drives one nibble onto the LCD pins: SETUP (E=0), PULSE (E=1), HOLD (E=0); done on last HOLD cycle.
// Latency T_SETUP+T_ENABLE+T_HOLD cycles from start; start is only acted on while idle.
module lcd_nibble_writer
  import lcd_bus_controller_pkg::*;
#(
  parameter int unsigned T_SETUP  = DEF_T_SETUP,
  parameter int unsigned T_ENABLE = DEF_T_ENABLE,
  parameter int unsigned T_HOLD   = DEF_T_HOLD
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_nibble,
  input  logic       i_rs,
  input  logic       i_clr,
  output logic       o_done,
  output logic       o_lcd_e,
  output logic       o_lcd_rs,
  output logic [3:0] o_lcd_dat
);

  localparam int unsigned CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  nib_state_t r_state;
  cnt_t       r_cnt;
  logic       r_e;
  logic       r_rs;
  logic [3:0] r_dat;
  logic       w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // Pins only change on SETUP entry, or when the controller returns to idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= NW_IDLE;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_dat   <= '0;
    end else begin
      if (i_clr) begin
        r_rs  <= 1'b0;
        r_dat <= '0;
      end
      case (r_state)
        NW_IDLE: begin
          if (i_start) begin
            r_state <= NW_SETUP;
            r_cnt   <= cnt_t'(tload(T_SETUP));
            r_rs    <= i_rs;
            r_dat   <= i_nibble;
          end
        end
        NW_SETUP: begin
          if (w_cnt_zero) begin
            r_state <= NW_PULSE;
            r_cnt   <= cnt_t'(tload(T_ENABLE));
            r_e     <= 1'b1;
          end else begin
            r_cnt <= r_cnt - cnt_t'(1);
          end
        end
        NW_PULSE: begin
          if (w_cnt_zero) begin
            r_state <= NW_HOLD;
            r_cnt   <= cnt_t'(tload(T_HOLD));
            r_e     <= 1'b0;
          end else begin
            r_cnt <= r_cnt - cnt_t'(1);
          end
        end
        NW_HOLD: begin
          if (w_cnt_zero) begin
            r_state <= NW_IDLE;
          end else begin
            r_cnt <= r_cnt - cnt_t'(1);
          end
        end
        default: r_state <= NW_IDLE;
      endcase
    end
  end

  assign o_done    = (r_state == NW_HOLD) && w_cnt_zero;
  assign o_lcd_e   = r_e;
  assign o_lcd_rs  = r_rs;
  assign o_lcd_dat = r_dat;

endmodule

// File: rtl/lcd_bus_controller.sv
// HD44780 4-bit sequencer: power-on init/config, then one byte per accepted write as two nibbles.
// Busy (rdy=0) from the cycle after acceptance until the exec wait ends; writes while busy are dropped.
module lcd_bus_controller
  import lcd_bus_controller_pkg::*;
#(
  parameter int unsigned T_POWERON = DEF_T_POWERON,
  parameter int unsigned T_INIT1   = DEF_T_INIT1,
  parameter int unsigned T_INIT2   = DEF_T_INIT2,
  parameter int unsigned T_SETUP   = DEF_T_SETUP,
  parameter int unsigned T_ENABLE  = DEF_T_ENABLE,
  parameter int unsigned T_HOLD    = DEF_T_HOLD,
  parameter int unsigned T_NIBGAP  = DEF_T_NIBGAP,
  parameter int unsigned T_EXEC    = DEF_T_EXEC,
  parameter int unsigned T_CLEAR   = DEF_T_CLEAR
) (
  input  logic                i_clk,
  input  logic                i_rst,
  lcd_bus_controller_if.slave bus
);

  ctrl_state_t r_state;
  timer_t      r_timer;
  timer_t      r_exec_ld;
  logic [2:0]  r_step;
  logic        r_boot;
  logic        r_single;
  logic        r_lower;
  logic        r_rs;
  logic [3:0]  r_lo_nib;
  logic        r_ready;

  logic        w_tdone;
  logic        w_accept;
  logic        w_clr;
  logic        w_start;
  logic        w_rs;
  logic [3:0]  w_nib;
  logic        w_done;
  logic [7:0]  w_cfg_byte;
  logic        w_lcd_e;
  logic        w_lcd_rs;
  logic [3:0]  w_lcd_dat;

  assign w_tdone    = (r_timer == '0);
  assign w_cfg_byte = cfg_byte(r_step[1:0]);
  assign w_accept   = (r_state == ST_IDLE) && r_ready && bus.wr_vld;
  // Leaving EXEC for IDLE: either a user byte, or the last config item (step 7).
  assign w_clr      = (r_state == ST_EXEC) && w_tdone && (!r_boot || (r_step == 3'd7));

  // Nibble launch is combinational so SETUP starts on the same edge the FSM commits.
  always_comb begin
    w_start = 1'b0;
    w_nib   = '0;
    w_rs    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_start = 1'b1;
        w_nib   = init_nibble(r_step[1:0]);
      end
      ST_CFG: begin
        w_start = 1'b1;
        w_nib   = w_cfg_byte[7:4];
      end
      ST_IDLE: begin
        w_start = w_accept;
        w_nib   = bus.wr_dat[7:4];
        w_rs    = bus.wr_rs;
      end
      ST_GAP: begin
        w_start = w_tdone;
        w_nib   = r_lo_nib;
        w_rs    = r_rs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_PWR_WAIT;
      r_timer   <= tload(T_POWERON);
      r_exec_ld <= '0;
      r_step    <= '0;
      r_boot    <= 1'b1;
      r_single  <= 1'b0;
      r_lower   <= 1'b0;
      r_rs      <= 1'b0;
      r_lo_nib  <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_PWR_WAIT: begin
          if (w_tdone) r_state <= ST_INIT;
          else         r_timer <= r_timer - timer_t'(1);
        end
        ST_INIT: begin
          r_single  <= 1'b1;
          r_lower   <= 1'b0;
          r_rs      <= 1'b0;
          r_lo_nib  <= '0;
          r_exec_ld <= (r_step == 3'd0) ? tload(T_INIT1) :
                       (r_step == 3'd1) ? tload(T_INIT2) : tload(T_EXEC);
          r_state   <= ST_NIB;
        end
        ST_CFG: begin
          r_single  <= 1'b0;
          r_lower   <= 1'b0;
          r_rs      <= 1'b0;
          r_lo_nib  <= w_cfg_byte[3:0];
          r_exec_ld <= is_long_cmd(1'b0, w_cfg_byte) ? tload(T_CLEAR) : tload(T_EXEC);
          r_state   <= ST_NIB;
        end
        ST_IDLE: begin
          if (w_accept) begin
            r_single  <= 1'b0;
            r_lower   <= 1'b0;
            r_rs      <= bus.wr_rs;
            r_lo_nib  <= bus.wr_dat[3:0];
            r_exec_ld <= is_long_cmd(bus.wr_rs, bus.wr_dat) ? tload(T_CLEAR) : tload(T_EXEC);
            r_ready   <= 1'b0;
            r_state   <= ST_NIB;
          end
        end
        ST_NIB: begin
          if (w_done) begin
            if (r_single || r_lower) begin
              r_state <= ST_EXEC;
              r_timer <= r_exec_ld;
            end else begin
              r_state <= ST_GAP;
              r_timer <= tload(T_NIBGAP);
              r_lower <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (w_tdone) r_state <= ST_NIB;
          else         r_timer <= r_timer - timer_t'(1);
        end
        ST_EXEC: begin
          if (w_tdone) begin
            if (w_clr) begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
              r_boot  <= 1'b0;
            end else begin
              r_step  <= r_step + 3'd1;
              r_state <= (r_step < 3'd3) ? ST_INIT : ST_CFG;
            end
          end else begin
            r_timer <= r_timer - timer_t'(1);
          end
        end
        default: r_state <= ST_PWR_WAIT;
      endcase
    end
  end

  lcd_nibble_writer #(
    .T_SETUP  (T_SETUP),
    .T_ENABLE (T_ENABLE),
    .T_HOLD   (T_HOLD)
  ) u_nib (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_start),
    .i_nibble  (w_nib),
    .i_rs      (w_rs),
    .i_clr     (w_clr),
    .o_done    (w_done),
    .o_lcd_e   (w_lcd_e),
    .o_lcd_rs  (w_lcd_rs),
    .o_lcd_dat (w_lcd_dat)
  );

  assign bus.rdy     = r_ready;
  assign bus.lcd_e   = w_lcd_e;
  assign bus.lcd_rs  = w_lcd_rs;
  assign bus.lcd_rw  = 1'b0;
  assign bus.lcd_dat = w_lcd_dat;

endmodule

// File: tb/tb_lcd_bus_controller.sv
// Directed + random stimulus for lcd_bus_controller; a pin monitor captures every E pulse and
// timing violations, and expectations come from the nibble/timing rules of the LCD protocol.
module tb_lcd_bus_controller;

  localparam int P_PWR = 20;
  localparam int P_I1  = 15;
  localparam int P_I2  = 10;
  localparam int P_S   = 2;
  localparam int P_EN  = 4;
  localparam int P_H   = 1;
  localparam int P_G   = 3;
  localparam int P_X   = 8;
  localparam int P_CLR = 30;

  localparam logic [3:0] BOOT_NIBS [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                            4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

  typedef struct {
    logic [4:0] pins;
    int         width;
    int         rise;
    int         fall;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd_bus_controller_if bus();

  lcd_bus_controller #(
    .T_POWERON (P_PWR), .T_INIT1 (P_I1), .T_INIT2 (P_I2),
    .T_SETUP   (P_S),   .T_ENABLE(P_EN), .T_HOLD  (P_H),
    .T_NIBGAP  (P_G),   .T_EXEC  (P_X),  .T_CLEAR (P_CLR)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         viol     = 0;
  int         rel_cyc  = 0;
  pulse_t     obs_q[$];
  logic [4:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: records each E pulse and flags setup/hold/mid-pulse data changes.
  logic       m_prev_e;
  logic [4:0] m_prev_pins;
  logic [4:0] m_pins;
  int         m_last_chg;
  int         m_last_fall;
  int         m_rise;
  always @(negedge clk) begin
    m_pins = {bus.lcd_rs, bus.lcd_dat};
    if (rst) begin
      m_prev_e    = 1'b0;
      m_prev_pins = m_pins;
      m_last_chg  = cyc;
      m_last_fall = -1000;
      m_rise      = cyc;
    end else begin
      if (m_pins !== m_prev_pins) begin
        if (bus.lcd_e === 1'b1 || (cyc - m_last_fall) < P_H) viol++;
        m_last_chg = cyc;
      end
      if (bus.lcd_e === 1'b1 && !m_prev_e) begin
        m_rise = cyc;
        if ((cyc - m_last_chg) < P_S) viol++;
      end
      if (bus.lcd_e !== 1'b1 && m_prev_e) begin
        m_last_fall = cyc;
        obs_q.push_back('{m_pins, cyc - m_rise, m_rise, cyc});
      end
      m_prev_e    = (bus.lcd_e === 1'b1);
      m_prev_pins = m_pins;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_low(input logic rs, input logic [7:0] b);
    int x;
    x = (!rs && (b == 8'h01 || b == 8'h02)) ? P_CLR : P_X;
    return 2 * (P_S + P_EN + P_H) + P_G + x;
  endfunction

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (bus.rdy !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.rdy !== 1'b1) chk("rdy_timeout", bus.rdy, 1);
  endtask

  // Issue one byte at a negedge with rdy=1; with spam, keep strobing random data while busy.
  task automatic send(input string tag, input logic rs, input logic [7:0] b, input bit spam);
    int low;
    bus.wr_vld = 1'b1;
    bus.wr_rs  = rs;
    bus.wr_dat = b;
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
    low = 0;
    @(negedge clk);
    if (!spam) bus.wr_vld = 1'b0;
    while (bus.rdy !== 1'b1 && low < 2000) begin
      low++;
      if (spam) begin
        bus.wr_rs  = 1'($urandom);
        bus.wr_dat = 8'($urandom);
      end
      @(negedge clk);
    end
    bus.wr_vld = 1'b0;
    chk({tag, "_busy_cycles"}, low, exp_low(rs, b));
  endtask

  task automatic check_pulses(input string tag);
    chk({tag, "_pulse_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s_pulse%0d_rs_dat", tag, i), obs_q[i].pins, exp_q[i]);
      chk($sformatf("%s_pulse%0d_e_width", tag, i), obs_q[i].width, P_EN);
    end
    chk({tag, "_timing_viol"}, viol, 0);
    chk({tag, "_idle_pins"}, {bus.lcd_rs, bus.lcd_dat}, 0);
    obs_q.delete();
    exp_q.delete();
    viol = 0;
  endtask

  task automatic boot_check(input string tag);
    int rc;
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, BOOT_NIBS[i]});
    chk({tag, "_rdy_low_at_start"}, bus.rdy, 0);
    wait_ready(5000);
    rc = cyc;
    if (obs_q.size() >= 12) begin
      chk({tag, "_no_e_before_poweron"}, (obs_q[0].rise - rel_cyc) >= P_PWR, 1);
      chk({tag, "_init1_wait"}, (obs_q[1].rise - obs_q[0].fall) >= (P_H + P_I1 + P_S), 1);
      chk({tag, "_init2_wait"}, (obs_q[2].rise - obs_q[1].fall) >= (P_H + P_I2 + P_S), 1);
      chk({tag, "_clear_wait"}, rc - obs_q[11].fall, P_H + P_CLR);
    end
    check_pulses(tag);
  endtask

  initial begin
    logic       rs;
    logic [7:0] b;
    bus.wr_vld = 1'b0;
    bus.wr_rs  = 1'b0;
    bus.wr_dat = '0;

    // Reset state
    rst = 1'b1;
    #1;
    chk("rst_rdy", bus.rdy, 0);
    chk("rst_e", bus.lcd_e, 0);
    chk("rst_rs", bus.lcd_rs, 0);
    chk("rst_dat", bus.lcd_dat, 0);
    chk("rst_rw", bus.lcd_rw, 0);
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    rel_cyc = cyc;
    boot_check("boot");
    chk("rw_tied_low", bus.lcd_rw, 0);

    // Character 'H', then long and short commands
    send("char_H", 1'b1, 8'h48, 1'b0);
    check_pulses("char_H");
    send("cmd_clear", 1'b0, 8'h01, 1'b0);
    send("cmd_ddram", 1'b0, 8'h80, 1'b0);
    send("cmd_home", 1'b0, 8'h02, 1'b0);
    send("data_01", 1'b1, 8'h01, 1'b0);
    check_pulses("cmds");

    // Strobe held through a whole transfer: one byte only, then a normal follow-up
    send("spam", 1'b1, 8'h5A, 1'b1);
    send("after_spam", 1'b0, 8'h0C, 1'b0);
    check_pulses("spam");

    // Random bytes with random idle gaps
    for (int k = 0; k < 10; k++) begin
      rs = 1'($urandom_range(0, 1));
      b  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rs = 1'b0;
        b  = 8'($urandom_range(1, 2));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send($sformatf("rand%0d", k), rs, b, 1'b0);
    end
    check_pulses("rand");

    // Reset while E is high in the middle of a byte
    bus.wr_vld = 1'b1;
    bus.wr_rs  = 1'b1;
    bus.wr_dat = 8'h58;
    @(negedge clk);
    bus.wr_vld = 1'b0;
    for (int k = 0; k < 100 && bus.lcd_e !== 1'b1; k++) @(negedge clk);
    chk("midrst_e_seen", bus.lcd_e, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_e_async", bus.lcd_e, 0);
    chk("midrst_rdy_async", bus.rdy, 0);
    repeat (3) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    viol    = 0;
    rst     = 1'b0;
    rel_cyc = cyc;
    boot_check("reboot");

    // Back-to-back "HOLA", each issued on the first rdy cycle
    send("hola_H", 1'b1, 8'h48, 1'b0);
    send("hola_O", 1'b1, 8'h4F, 1'b0);
    send("hola_L", 1'b1, 8'h4C, 1'b0);
    send("hola_A", 1'b1, 8'h41, 1'b0);
    check_pulses("hola");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
